lfsr247_check: RTL and testbench

Serial receive-side checker for the 247-bit LFSR pattern produced by `lfsr247`. It consumes one pattern bit per `next` strobe and self-synchronises by loading the first 247 received bits as its seed. It then predicts every following bit, flags and counts mismatches, and drops lock when the error density gets too high. It sits at the far end of any path the `lfsr247` stream is sent over, and supplies the pass/fail verdict for that path.

---
 rtl/lfsr247_pkg.sv | 30 +++
 rtl/err_window.sv | 49 ++++
 rtl/lfsr247_check.sv | 121 ++++++++++++
 tb/tb_lfsr247_check.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/lfsr247_pkg.sv
// lfsr247_pkg
// Shared definitions for the 247-bit LFSR pattern generator and its checker.
// Holds the polynomial constants (x^247 + x^165 + 1), the checker's error
// monitor sizing, the checker state encoding and the feedback function used
// by both ends of the link so they can never disagree on the sequence.
package lfsr247_pkg;

  localparam int WIDTH       = 247;
  localparam int TAP         = 165;
  localparam int WIN         = 64;
  localparam int LOSS_THRESH = 8;
  localparam int CNT_W       = 32;

  // Counter widths derived from the constants above
  localparam int WIN_W  = $clog2(WIN);
  localparam int WERR_W = $clog2(LOSS_THRESH + 1);
  localparam int ACQ_W  = $clog2(WIDTH + 1);

  typedef enum logic {
    ST_ACQ  = 1'b0,
    ST_LOCK = 1'b1
  } chk_state_t;

  // Next bit of the sequence given the current shift register contents,
  // where s[0] holds the most recent bit.
  function automatic logic lfsr247_fb(input logic [WIDTH-1:0] s);
    return s[WIDTH-1] ^ s[TAP-1];
  endfunction

endpackage

// File: rtl/err_window.sv
// err_window
// Error-density monitor for the locked checker. Counts accepted bits modulo
// WIN and the errors seen inside the current window, and raises lose when the
// bit being accepted would bring the window's error count to LOSS_THRESH.
// Ports:
//   clk, init_n : clock and asynchronous active-low reset
//   tick        : a bit is being accepted while locked
//   bit_err     : that bit mismatched the prediction
//   clear       : restart the window (taken when lock is dropped)
//   lose        : combinational loss-of-lock request for this tick
module err_window
  import lfsr247_pkg::*;
(
  input  logic clk,
  input  logic init_n,
  input  logic tick,
  input  logic bit_err,
  input  logic clear,
  output logic lose
);

  logic [WIN_W-1:0]  win_cnt;
  logic [WERR_W-1:0] win_err;
  logic [WERR_W-1:0] err_sum;

  assign err_sum = win_err + WERR_W'(bit_err);
  assign lose    = tick && (err_sum >= WERR_W'(LOSS_THRESH));

  // Window bookkeeping. At a window wrap the erring wrap bit is carried into
  // the new window so an error burst straddling the boundary is still seen.
  always_ff @(posedge clk or negedge init_n) begin
    if (!init_n) begin
      win_cnt <= '0;
      win_err <= '0;
    end else if (clear) begin
      win_cnt <= '0;
      win_err <= '0;
    end else if (tick) begin
      if (win_cnt == WIN_W'(WIN - 1)) begin
        win_cnt <= '0;
        win_err <= WERR_W'(bit_err);
      end else begin
        win_cnt <= win_cnt + 1'b1;
        win_err <= err_sum;
      end
    end
  end

endmodule

// File: rtl/lfsr247_check.sv
// lfsr247_check
// Receive-side checker for the 247-bit LFSR pattern. Loads the first WIDTH
// received bits as its seed, then flywheels its own prediction and compares
// every received bit against it, counting bits and mismatches. Drops back to
// acquisition when the error monitor reports too dense an error burst.
// Ports:
//   clk, init_n : clock and asynchronous active-low reset
//   next, din   : one received bit accepted per cycle with next high
//   clr         : synchronous clear of bit_cnt, err_cnt and sticky_err
//   locked      : checker synchronised
//   err         : one-cycle mismatch pulse for the last accepted bit
//   sticky_err  : latched err, cleared by clr or reset
//   bit_cnt     : saturating count of bits checked while locked
//   err_cnt     : saturating count of mismatches while locked
//   value       : checker shift register, for debug
module lfsr247_check
  import lfsr247_pkg::*;
(
  input  logic             clk,
  input  logic             init_n,
  input  logic             next,
  input  logic             din,
  input  logic             clr,
  output logic             locked,
  output logic             err,
  output logic             sticky_err,
  output logic [CNT_W-1:0] bit_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic [WIDTH-1:0] value
);

  chk_state_t       state, state_n;
  logic [WIDTH-1:0] s, s_n;
  logic [ACQ_W-1:0] acq_cnt, acq_cnt_n;
  logic             pred;
  logic             lock_tick;
  logic             bit_err;
  logic             lose;

  assign pred      = lfsr247_fb(s);
  assign lock_tick = next && (state == ST_LOCK);
  assign bit_err   = lock_tick && (din != pred);

  err_window u_err_window (
    .clk     (clk),
    .init_n  (init_n),
    .tick    (lock_tick),
    .bit_err (bit_err),
    .clear   (lose),
    .lose    (lose)
  );

  // Next-state logic. While locked the register shifts in its own prediction
  // rather than din, so a corrupted line bit cannot poison later predictions.
  // An all-zero seed is a lockup state of the LFSR and is never accepted.
  always_comb begin
    state_n   = state;
    acq_cnt_n = acq_cnt;
    s_n       = s;
    if (next) begin
      case (state)
        ST_ACQ: begin
          s_n = {s[WIDTH-2:0], din};
          if (acq_cnt == ACQ_W'(WIDTH - 1)) begin
            acq_cnt_n = '0;
            if (s_n != '0) state_n = ST_LOCK;
          end else begin
            acq_cnt_n = acq_cnt + 1'b1;
          end
        end
        ST_LOCK: begin
          s_n = {s[WIDTH-2:0], pred};
          if (lose) begin
            state_n   = ST_ACQ;
            acq_cnt_n = '0;
          end
        end
        default: state_n = ST_ACQ;
      endcase
    end
  end

  // State, shift register and acquisition counter
  always_ff @(posedge clk or negedge init_n) begin
    if (!init_n) begin
      state   <= ST_ACQ;
      s       <= '0;
      acq_cnt <= '0;
    end else begin
      state   <= state_n;
      s       <= s_n;
      acq_cnt <= acq_cnt_n;
    end
  end

  // Result counters. clr wins over a bit counted in the same cycle, but the
  // err pulse still reports that bit.
  always_ff @(posedge clk or negedge init_n) begin
    if (!init_n) begin
      err        <= 1'b0;
      sticky_err <= 1'b0;
      bit_cnt    <= '0;
      err_cnt    <= '0;
    end else begin
      err <= bit_err;
      if (clr) begin
        sticky_err <= 1'b0;
        bit_cnt    <= '0;
        err_cnt    <= '0;
      end else begin
        if (bit_err) sticky_err <= 1'b1;
        if (lock_tick && (bit_cnt != '1)) bit_cnt <= bit_cnt + 1'b1;
        if (bit_err && (err_cnt != '1)) err_cnt <= err_cnt + 1'b1;
      end
    end
  end

  assign locked = (state == ST_LOCK);
  assign value  = s;

endmodule

// File: tb/tb_lfsr247_check.sv
// tb_lfsr247_check
// Drives lfsr247_check with pattern streams produced from the x^247 + x^165 + 1
// recurrence and compares every output each cycle with a reference model that
// keeps the checker's bit history as a queue.
module tb_lfsr247_check;

  localparam int W      = 247;
  localparam int T      = 165;
  localparam int WINLEN = 64;
  localparam int THRESH = 8;
  localparam int NSTREAM = 2700;

  logic        clk = 1'b0;
  logic        init_n;
  logic        next;
  logic        din;
  logic        clr;
  logic        locked;
  logic        err;
  logic        sticky_err;
  logic [31:0] bit_cnt;
  logic [31:0] err_cnt;
  logic [W-1:0] value;

  int checks = 0;
  int fails  = 0;

  bit stream [NSTREAM];

  // Reference model state
  bit          hist[$];
  bit          m_locked;
  bit          m_err;
  bit          m_sticky;
  int          acq_n;
  int          win_pos;
  int          win_errs;
  logic [31:0] m_bit_cnt;
  logic [31:0] m_err_cnt;

  lfsr247_check dut (
    .clk        (clk),
    .init_n     (init_n),
    .next       (next),
    .din        (din),
    .clr        (clr),
    .locked     (locked),
    .err        (err),
    .sticky_err (sticky_err),
    .bit_cnt    (bit_cnt),
    .err_cnt    (err_cnt),
    .value      (value)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic genStream();
    for (int i = 0; i < W; i++) stream[i] = 1'($urandom % 2);
    stream[0] = 1'b1;
    for (int i = W; i < NSTREAM; i++) stream[i] = stream[i-W] ^ stream[i-T];
  endtask

  task automatic modelReset();
    hist.delete();
    for (int i = 0; i < W; i++) hist.push_back(1'b0);
    m_locked  = 1'b0;
    m_err     = 1'b0;
    m_sticky  = 1'b0;
    acq_n     = 0;
    win_pos   = 0;
    win_errs  = 0;
    m_bit_cnt = '0;
    m_err_cnt = '0;
  endtask

  // hist[0] is the oldest of the last W bits, hist[W-1] the newest
  task automatic modelStep(input bit n, input bit d, input bit c);
    bit p;
    bit e;
    bit any;
    m_err = 1'b0;
    if (n) begin
      if (!m_locked) begin
        hist.push_back(d);
        void'(hist.pop_front());
        acq_n++;
        if (acq_n == W) begin
          acq_n = 0;
          any = 1'b0;
          foreach (hist[k]) any |= hist[k];
          if (any) m_locked = 1'b1;
        end
      end else begin
        p = hist[0] ^ hist[W-T];
        e = (d != p);
        hist.push_back(p);
        void'(hist.pop_front());
        m_err = e;
        if (!c) begin
          if (m_bit_cnt != 32'hFFFF_FFFF) m_bit_cnt++;
          if (e && m_err_cnt != 32'hFFFF_FFFF) m_err_cnt++;
          if (e) m_sticky = 1'b1;
        end
        win_errs += int'(e);
        if (win_errs >= THRESH) begin
          m_locked = 1'b0;
          acq_n    = 0;
          win_pos  = 0;
          win_errs = 0;
        end else begin
          win_pos++;
          if (win_pos == WINLEN) begin
            win_pos  = 0;
            win_errs = int'(e);
          end
        end
      end
    end
    if (c) begin
      m_bit_cnt = '0;
      m_err_cnt = '0;
      m_sticky  = 1'b0;
    end
  endtask

  function automatic logic [W-1:0] modelValue();
    logic [W-1:0] v;
    for (int k = 0; k < W; k++) v[k] = hist[W-1-k];
    return v;
  endfunction

  task automatic checkAll(input string tag);
    checkOutput({tag, "_locked"}, 256'(locked), 256'(m_locked));
    checkOutput({tag, "_err"}, 256'(err), 256'(m_err));
    checkOutput({tag, "_sticky"}, 256'(sticky_err), 256'(m_sticky));
    checkOutput({tag, "_bit_cnt"}, 256'(bit_cnt), 256'(m_bit_cnt));
    checkOutput({tag, "_err_cnt"}, 256'(err_cnt), 256'(m_err_cnt));
    checkOutput({tag, "_value"}, 256'(value), 256'(modelValue()));
  endtask

  task automatic applyStimulus(input bit n, input bit d, input bit c, input string tag);
    next = n;
    din  = d;
    clr  = c;
    @(posedge clk);
    modelStep(n, d, c);
    #1;
    checkAll(tag);
  endtask

  task automatic doReset();
    @(negedge clk);
    init_n = 1'b0;
    next   = 1'b0;
    clr    = 1'b0;
    modelReset();
    #1;
    checkAll("rst");
    @(negedge clk);
    init_n = 1'b1;
  endtask

  initial begin
    int pulses;
    int idx;
    bit n;

    init_n = 1'b0;
    next   = 1'b0;
    din    = 1'b0;
    clr    = 1'b0;
    modelReset();
    genStream();
    repeat (2) @(posedge clk);
    #1;
    checkAll("reset");
    @(negedge clk);
    init_n = 1'b1;

    // Clean continuous stream: lock after 247 bits, then 1753 checked bits
    $display("[TB] clean continuous stream");
    for (int i = 0; i < 2000; i++) begin
      applyStimulus(1'b1, stream[i], 1'b0, "p1");
      if (i == W - 2) checkOutput("p1_not_yet_locked", 256'(locked), 256'(0));
      if (i == W - 1) checkOutput("p1_locked_at_247", 256'(locked), 256'(1));
    end
    checkOutput("p1_bit_cnt_final", 256'(bit_cnt), 256'(1753));
    checkOutput("p1_err_cnt_final", 256'(err_cnt), 256'(0));

    // Three isolated bit errors 100 bits apart
    $display("[TB] isolated errors");
    pulses = 0;
    for (int i = 2000; i < 2300; i++) begin
      applyStimulus(1'b1, stream[i] ^ ((i == 2050) || (i == 2150) || (i == 2250)), 1'b0, "p2");
      if (err) pulses++;
    end
    checkOutput("p2_err_pulses", 256'(pulses), 256'(3));
    checkOutput("p2_err_cnt", 256'(err_cnt), 256'(3));
    checkOutput("p2_sticky", 256'(sticky_err), 256'(1));
    checkOutput("p2_locked", 256'(locked), 256'(1));

    // Clear while locked, then an 8-bit error burst forcing loss and relock
    $display("[TB] error burst");
    applyStimulus(1'b0, 1'b0, 1'b1, "p3clr");
    checkOutput("p3_clr_err_cnt", 256'(err_cnt), 256'(0));
    checkOutput("p3_clr_bit_cnt", 256'(bit_cnt), 256'(0));
    checkOutput("p3_clr_locked", 256'(locked), 256'(1));
    for (int i = 2300; i < 2308; i++) begin
      applyStimulus(1'b1, ~stream[i], 1'b0, "p3");
      if (i == 2306) checkOutput("p3_still_locked_7", 256'(locked), 256'(1));
    end
    checkOutput("p3_lost", 256'(locked), 256'(0));
    checkOutput("p3_err_cnt_8", 256'(err_cnt), 256'(8));
    for (int i = 2308; i < 2600; i++) begin
      applyStimulus(1'b1, stream[i], 1'b0, "p3r");
      if (i == 2308 + W - 2) checkOutput("p3_relock_early", 256'(locked), 256'(0));
      if (i == 2308 + W - 1) checkOutput("p3_relock", 256'(locked), 256'(1));
    end
    checkOutput("p3_err_cnt_end", 256'(err_cnt), 256'(8));

    // All-zero input must never lock
    $display("[TB] all-zero input");
    doReset();
    for (int i = 0; i < 300; i++) applyStimulus(1'b1, 1'b0, 1'b0, "p4");
    checkOutput("p4_locked", 256'(locked), 256'(0));
    checkOutput("p4_bit_cnt", 256'(bit_cnt), 256'(0));

    // Same clean stream with next at about 30% duty and junk din when idle
    $display("[TB] gapped stream");
    doReset();
    idx = 0;
    while (idx < 2000) begin
      n = ($urandom_range(0, 99) < 30);
      applyStimulus(n, n ? stream[idx] : 1'($urandom % 2), 1'b0, "p5");
      if (n) idx++;
    end
    checkOutput("p5_bit_cnt_final", 256'(bit_cnt), 256'(1753));
    checkOutput("p5_err_cnt_final", 256'(err_cnt), 256'(0));
    checkOutput("p5_locked", 256'(locked), 256'(1));

    // clr coinciding with an erroring bit: err pulses, nothing is counted
    $display("[TB] clear and mid-stream reset");
    applyStimulus(1'b1, ~stream[2000], 1'b1, "p6");
    checkOutput("p6_clr_err_pulse", 256'(err), 256'(1));
    checkOutput("p6_clr_sticky", 256'(sticky_err), 256'(0));
    checkOutput("p6_clr_err_cnt", 256'(err_cnt), 256'(0));
    for (int i = 2001; i < 2010; i++) applyStimulus(1'b1, stream[i], 1'b0, "p6");
    checkOutput("p6_bit_cnt_9", 256'(bit_cnt), 256'(9));
    @(negedge clk);
    init_n = 1'b0;
    #1;
    checkOutput("p6_rst_locked", 256'(locked), 256'(0));
    checkOutput("p6_rst_bit_cnt", 256'(bit_cnt), 256'(0));
    checkOutput("p6_rst_value", 256'(value), 256'(0));
    modelReset();
    @(negedge clk);
    init_n = 1'b1;
    applyStimulus(1'b1, stream[0], 1'b0, "p6post");

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
